// File: rtl/compare_search_ctrl.sv
// Successive-approximation search over a signed operand, driving an external comparator's X
// input one trial per clock and steering on its Equal/Larger/Smaller flags.
module compare_search_ctrl #(
    parameter int n = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     cmp_equal,
    input  logic                     cmp_smaller,
    input  logic                     cmp_larger,
    output logic [n-1:0]             trial,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [n-1:0]             result,
    output logic [$clog2(n+1)-1:0]   steps
);

    localparam int BW = $clog2(n);
    localparam int SW = $clog2(n+1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        CHECK
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [n-1:0]    acc;
    logic [n-1:0]    acc_next;
    logic [n-1:0]    bit_mask;
    logic [n-1:0]    msb_mask;
    logic [BW-1:0]   b;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   cnt_inc;
    logic            launch;

    assign msb_mask = {1'b1, {(n-1){1'b0}}};
    assign bit_mask = {{(n-1){1'b0}}, 1'b1} << b;
    assign cnt_inc  = cnt + 1'b1;
    assign launch   = start && !abort;

    // acc is offset binary, so XOR with the MSB converts it to the signed trial value
    always_comb begin
        acc_next = acc;
        if (cmp_equal) begin
            acc_next = acc;
        end else if (cmp_larger) begin
            acc_next = acc;
        end else if (cmp_smaller) begin
            acc_next = acc | bit_mask;
        end else begin
            acc_next = acc | bit_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (abort || cmp_equal) begin
                    state_next = IDLE;
                end else if (b == '0) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Abort wins over completion: the cycle is discarded and the reported outputs keep their values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            b      <= '0;
            cnt    <= '0;
            trial  <= '0;
            result <= '0;
            steps  <= '0;
            found  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        acc   <= '0;
                        b     <= BW'(n-1);
                        cnt   <= '0;
                        trial <= '0;
                    end
                end
                SEARCH: begin
                    if (!abort) begin
                        cnt <= cnt_inc;
                        if (cmp_equal) begin
                            result <= trial;
                            found  <= 1'b1;
                            steps  <= cnt_inc;
                            done   <= 1'b1;
                        end else begin
                            acc <= acc_next;
                            if (b == '0) begin
                                trial <= acc_next ^ msb_mask;
                            end else begin
                                b     <= b - 1'b1;
                                trial <= (acc_next | (bit_mask >> 1)) ^ msb_mask;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (!abort) begin
                        result <= trial;
                        found  <= cmp_equal;
                        steps  <= cnt_inc;
                        done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_search_ctrl.sv
// Directed bench for compare_search_ctrl at n=8; the comparator is modelled from trial and y,
// with an override that forces every flag low.
module tb_compare_search_ctrl;

    localparam int N = 8;

    logic                  clk;
    logic                  reset_n;
    logic                  start;
    logic                  abort;
    logic                  cmp_equal;
    logic                  cmp_smaller;
    logic                  cmp_larger;
    logic [N-1:0]          trial;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [N-1:0]          result;
    logic [$clog2(N+1)-1:0] steps;

    logic signed [N-1:0]   y;
    logic                  force_low;
    int                    tests;
    int                    fails;

    compare_search_ctrl #(.n(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .cmp_equal(cmp_equal),
        .cmp_smaller(cmp_smaller),
        .cmp_larger(cmp_larger),
        .trial(trial),
        .busy(busy),
        .done(done),
        .found(found),
        .result(result),
        .steps(steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cmp_equal   = 1'b0;
        cmp_smaller = 1'b0;
        cmp_larger  = 1'b0;
        if (!force_low) begin
            cmp_equal   = ($signed(trial) == y);
            cmp_smaller = ($signed(trial) < y);
            cmp_larger  = ($signed(trial) > y);
        end
    end

    task automatic test_reset();
        #1;
        tests++;
        if (trial !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 ||
            result !== 8'd0 || steps !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset: trial=%0d busy=%b done=%b found=%b result=%0d steps=%0d, required all zero",
                     trial, busy, done, found, result, steps);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_search(input string name, input logic signed [N-1:0] yv, input bit low,
                               input int exp_trials[10], input int ntr,
                               input logic exp_found, input int exp_result, input int exp_steps);
        logic [N-1:0] et;
        @(negedge clk);
        y = yv;
        force_low = low;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < ntr; i++) begin
            et = N'(exp_trials[i]);
            tests++;
            if (trial !== et || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s trial[%0d]: got %0d busy=%b done=%b, required %0d busy=1 done=0",
                         name, i, $signed(trial), busy, done, $signed(et));
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || found !== exp_found ||
            result !== N'(exp_result) || steps !== 4'(exp_steps)) begin
            fails++;
            $display("[TB] FAIL %s done: done=%b busy=%b found=%b result=%0d steps=%0d, required 1 0 %b %0d %0d",
                     name, done, busy, found, $signed(result), steps, exp_found, exp_result, exp_steps);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || trial !== et) begin
            fails++;
            $display("[TB] FAIL %s after: done=%b trial=%0d, required done=0 trial=%0d",
                     name, done, $signed(trial), $signed(et));
        end
        force_low = 1'b0;
    endtask

    task automatic test_abort();
        @(negedge clk);
        y = 8'sd37;
        start = 1'b1;
        @(negedge clk);
        tests++;
        if (trial !== 8'd0) begin
            fails++;
            $display("[TB] FAIL abort_t0: got %0d required 0", trial);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (trial !== 8'd64) begin
            fails++;
            $display("[TB] FAIL busy_start_ignored: trial=%0d required 64", trial);
        end
        @(negedge clk);
        tests++;
        if (trial !== 8'd32) begin
            fails++;
            $display("[TB] FAIL abort_t2: got %0d required 32", trial);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd127 || steps !== 4'd8 ||
            found !== 1'b1 || trial !== 8'd32) begin
            fails++;
            $display("[TB] FAIL abort: busy=%b done=%b result=%0d steps=%0d found=%b trial=%0d, required 0 0 127 8 1 32",
                     busy, done, result, steps, found, trial);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_nodone: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || trial !== 8'd32) begin
            fails++;
            $display("[TB] FAIL start_abort_idle: busy=%b trial=%0d required 0 32", busy, trial);
        end
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd127) begin
            fails++;
            $display("[TB] FAIL abort_idle: busy=%b done=%b result=%0d required 0 0 127", busy, done, result);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        y = 8'sd37;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (trial !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 ||
            result !== 8'd0 || steps !== 4'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: trial=%0d busy=%b done=%b found=%b result=%0d steps=%0d, required all zero",
                     trial, busy, done, found, result, steps);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset_after: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        force_low = 1'b0;
        y         = '0;
        test_reset();
        test_search("y37", 8'sd37, 1'b0, '{0, 64, 32, 48, 40, 36, 38, 37, 0, 0}, 8, 1'b1, 37, 8);
        test_search("y0", 8'sd0, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1, 0, 1);
        test_search("ymin", -8'sd128, 1'b0,
                    '{0, -64, -96, -112, -120, -124, -126, -127, -128, 0}, 9, 1'b1, -128, 9);
        test_search("ymax", 8'sd127, 1'b0, '{0, 64, 96, 112, 120, 124, 126, 127, 0, 0}, 8, 1'b1, 127, 8);
        test_abort();
        test_abort_idle();
        test_search("noflags", 8'sd5, 1'b1, '{0, 64, 96, 112, 120, 124, 126, 127, 127, 0}, 9, 1'b0, 127, 9);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
